// File: rtl/io_2to1_pkg.sv
// Shared sizes, FSM encodings and helpers for the two-source / one-sink channel checker.
package io_2to1_pkg;

    localparam int unsigned NS_ADDRESS_SIZE = 8;
    localparam int unsigned NS_DATA_SIZE    = 8;

    // Width of the rolling sequence number carried in dat[3:0].
    localparam int unsigned SEQ_W = 4;
    // Sink ack delay counter width; ACK_DLY is limited to 0..15.
    localparam int unsigned DLY_W = 4;

    typedef logic [SEQ_W-1:0] seq_t;
    typedef logic [DLY_W-1:0] dly_t;

    typedef enum logic [1:0] {
        SIdle,
        SReq,
        SDrop
    } src_state_e;

    typedef enum logic [1:0] {
        KIdle,
        KWait,
        KAck
    } snk_state_e;

    function automatic seq_t seq_next(input seq_t v);
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/io_2to1_src.sv
// Four-phase channel source emitting a wrapping 4-bit sequence number.
module io_2to1_src
    import io_2to1_pkg::*;
#(
    parameter int unsigned ASZ      = NS_ADDRESS_SIZE,
    parameter int unsigned DSZ      = NS_DATA_SIZE,
    parameter int unsigned SRC_ADDR = 1,
    parameter int unsigned DST_ADDR = 3
) (
    input  logic           clk,
    input  logic           rst,
    output logic [ASZ-1:0] src,
    output logic [ASZ-1:0] dst,
    output logic [DSZ-1:0] dat,
    output logic           req,
    input  logic           ack
);

    src_state_e state_q, state_d;
    seq_t       seq_q, seq_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SIdle;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        case (state_q)
            SIdle: begin
                // req is already low in SIdle, so only ack needs to be clear.
                if (!ack) begin
                    state_d = SReq;
                end
            end
            SReq: begin
                if (ack) begin
                    state_d = SDrop;
                    seq_d   = seq_next(seq_q);
                end
            end
            SDrop: begin
                if (!ack) begin
                    state_d = SIdle;
                end
            end
            default: state_d = SIdle;
        endcase
    end

    // Data only changes when leaving SReq, so fields are stable while req is high.
    always_comb begin
        src = ASZ'(SRC_ADDR);
        dst = ASZ'(DST_ADDR);
        dat = DSZ'(seq_q);
        req = (state_q == SReq);
    end

endmodule

// File: rtl/io_2to1.sv
// Two channel sources plus a checking sink that tracks per-source continuity and counts.
module io_2to1
    import io_2to1_pkg::*;
#(
    parameter int unsigned SRC_ADDR_0 = 1,
    parameter int unsigned SRC_ADDR_1 = 2,
    parameter int unsigned DST_ADDR   = 3,
    parameter int unsigned ACK_DLY    = 0,
    parameter int unsigned ASZ        = NS_ADDRESS_SIZE,
    parameter int unsigned DSZ        = NS_DATA_SIZE
) (
    input  logic           i_clk,
    input  logic           i_rst,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [ASZ-1:0] o1_src,
    output logic [ASZ-1:0] o1_dst,
    output logic [DSZ-1:0] o1_dat,
    output logic           o1_req,
    input  logic           o1_ack,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic [DSZ-1:0] o_0_ck_dat,
    output logic [DSZ-1:0] o_1_ck_dat,
    output logic [7:0]     o_0_cnt,
    output logic [7:0]     o_1_cnt,
    output logic           o_err
);

    io_2to1_src #(
        .ASZ      (ASZ),
        .DSZ      (DSZ),
        .SRC_ADDR (SRC_ADDR_0),
        .DST_ADDR (DST_ADDR)
    ) u_src0 (
        .clk (i_clk),
        .rst (i_rst),
        .src (o0_src),
        .dst (o0_dst),
        .dat (o0_dat),
        .req (o0_req),
        .ack (o0_ack)
    );

    io_2to1_src #(
        .ASZ      (ASZ),
        .DSZ      (DSZ),
        .SRC_ADDR (SRC_ADDR_1),
        .DST_ADDR (DST_ADDR)
    ) u_src1 (
        .clk (i_clk),
        .rst (i_rst),
        .src (o1_src),
        .dst (o1_dst),
        .dat (o1_dat),
        .req (o1_req),
        .ack (o1_ack)
    );

    snk_state_e     st_q, st_d;
    dly_t           dly_q, dly_d;
    logic [ASZ-1:0] cap_src_q, cap_src_d;
    logic [ASZ-1:0] cap_dst_q, cap_dst_d;
    logic [DSZ-1:0] cap_dat_q, cap_dat_d;
    logic [DSZ-1:0] ck0_q, ck0_d;
    logic [DSZ-1:0] ck1_q, ck1_d;
    logic [7:0]     cnt0_q, cnt0_d;
    logic [7:0]     cnt1_q, cnt1_d;
    logic           seen0_q, seen0_d;
    logic           seen1_q, seen1_d;
    logic           err_q, err_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q      <= KIdle;
            dly_q     <= '0;
            cap_src_q <= '0;
            cap_dst_q <= '0;
            cap_dat_q <= '0;
            ck0_q     <= '1;
            ck1_q     <= '1;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            seen0_q   <= 1'b0;
            seen1_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            dly_q     <= dly_d;
            cap_src_q <= cap_src_d;
            cap_dst_q <= cap_dst_d;
            cap_dat_q <= cap_dat_d;
            ck0_q     <= ck0_d;
            ck1_q     <= ck1_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            seen0_q   <= seen0_d;
            seen1_q   <= seen1_d;
            err_q     <= err_d;
        end
    end

    // Message checks, evaluated on the captured fields.
    logic hit0, hit1, dst_bad, dat_bad, seq_bad0, seq_bad1, msg_bad;

    always_comb begin
        hit0     = (cap_src_q == ASZ'(SRC_ADDR_0));
        hit1     = !hit0 && (cap_src_q == ASZ'(SRC_ADDR_1));
        dst_bad  = (cap_dst_q != ASZ'(DST_ADDR));
        dat_bad  = (cap_dat_q > DSZ'(15));
        seq_bad0 = seen0_q && (cap_dat_q[SEQ_W-1:0] != seq_next(ck0_q[SEQ_W-1:0]));
        seq_bad1 = seen1_q && (cap_dat_q[SEQ_W-1:0] != seq_next(ck1_q[SEQ_W-1:0]));
        msg_bad  = dst_bad || dat_bad || !(hit0 || hit1) ||
                   (hit0 && seq_bad0) || (hit1 && seq_bad1);
    end

    always_comb begin
        st_d      = st_q;
        dly_d     = dly_q;
        cap_src_d = cap_src_q;
        cap_dst_d = cap_dst_q;
        cap_dat_d = cap_dat_q;
        ck0_d     = ck0_q;
        ck1_d     = ck1_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        seen0_d   = seen0_q;
        seen1_d   = seen1_q;
        err_d     = err_q;
        case (st_q)
            KIdle: begin
                if (i0_req) begin
                    st_d      = KWait;
                    cap_src_d = i0_src;
                    cap_dst_d = i0_dst;
                    cap_dat_d = i0_dat;
                    dly_d     = DLY_W'(ACK_DLY);
                end
            end
            KWait: begin
                if (!i0_req) begin
                    // Requester withdrew before being acked.
                    st_d  = KIdle;
                    err_d = 1'b1;
                end else if (dly_q != '0) begin
                    dly_d = dly_q - 1'b1;
                end else begin
                    st_d = KAck;
                    if (msg_bad) begin
                        err_d = 1'b1;
                    end
                    if (hit0) begin
                        ck0_d   = cap_dat_q;
                        cnt0_d  = cnt0_q + 8'd1;
                        seen0_d = 1'b1;
                    end else if (hit1) begin
                        ck1_d   = cap_dat_q;
                        cnt1_d  = cnt1_q + 8'd1;
                        seen1_d = 1'b1;
                    end
                end
            end
            KAck: begin
                if (!i0_req) begin
                    st_d = KIdle;
                end
            end
            default: st_d = KIdle;
        endcase
    end

    always_comb begin
        i0_ack     = (st_q == KAck);
        o_0_ck_dat = ck0_q;
        o_1_ck_dat = ck1_q;
        o_0_cnt    = cnt0_q;
        o_1_cnt    = cnt1_q;
        o_err      = err_q;
    end

endmodule
